// File: rtl/alut_pkg.sv
// Shared ALUT definitions: entry field layout and the aging-engine state encoding.
// Also imported by the address checker on the add port.
package alut_pkg;

  localparam int MAC_LSB   = 0;
  localparam int TS_LSB    = 48;
  localparam int PORT_LSB  = 80;
  localparam int VALID_BIT = 82;
  localparam int TS_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EVAL = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } age_state_e;

endpackage

// File: rtl/alut_age_cmp.sv
// Combinational staleness decision for one ALUT entry.
// The subtraction is 32-bit modulo, so a time base that has wrapped still yields the true age.
module alut_age_cmp
  import alut_pkg::*;
#(
  parameter int DW = 83
) (
  input  logic [DW-1:0]   entry_i,
  input  logic [TS_W-1:0] curr_time_i,
  input  logic [TS_W-1:0] thr_i,
  output logic            stale_o
);

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] age;
  logic            unused_fields;

  assign ts  = entry_i[TS_LSB +: TS_W];
  assign age = curr_time_i - ts;

  // mac and port never influence the decision
  assign unused_fields = ^{entry_i[MAC_LSB +: 48], entry_i[PORT_LSB +: 2]};

  assign stale_o = entry_i[VALID_BIT] && (thr_i != '0) && (age >= thr_i);

endmodule

// File: rtl/alut_age_scan.sv
// ALUT aging engine: one pass reads every entry, clears the stale ones, and backs off
// to a reread whenever the add port writes the entry currently being examined.
module alut_age_scan
  import alut_pkg::*;
#(
  parameter int DW = 83,
  parameter int DD = 256,
  parameter int AW = 8
) (
  input  logic          pclk,
  input  logic          p_reset,
  input  logic          age_start,
  input  logic [31:0]   curr_time,
  input  logic [31:0]   age_threshold,
  input  logic [AW-1:0] mem_addr_add,
  input  logic          mem_write_add,
  input  logic [DW-1:0] mem_read_data_age,
  output logic [AW-1:0] mem_addr_age,
  output logic          mem_write_age,
  output logic [DW-1:0] mem_write_data_age,
  output logic          age_busy,
  output logic          age_done,
  output logic [AW:0]   aged_count,
  output age_state_e    age_state_dbg
);

  age_state_e    state_q, state_d;
  logic [AW-1:0] scan_addr_q, scan_addr_d;
  logic [AW:0]   aged_count_q, aged_count_d;
  logic [AW-1:0] addr_hold_q;
  logic          stale;
  logic          collide;
  logic          last_addr;

  alut_age_cmp #(.DW(DW)) u_cmp (
    .entry_i     (mem_read_data_age),
    .curr_time_i (curr_time),
    .thr_i       (age_threshold),
    .stale_o     (stale)
  );

  assign collide   = mem_write_add && (mem_addr_add == scan_addr_q);
  assign last_addr = (scan_addr_q == AW'(DD - 1));

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state_q      <= ST_IDLE;
      scan_addr_q  <= '0;
      aged_count_q <= '0;
      addr_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      scan_addr_q  <= scan_addr_d;
      aged_count_q <= aged_count_d;
      addr_hold_q  <= mem_addr_age;
    end
  end

  always_comb begin
    state_d      = state_q;
    scan_addr_d  = scan_addr_q;
    aged_count_d = aged_count_q;
    case (state_q)
      ST_IDLE: begin
        if (age_start) begin
          state_d      = ST_RD;
          scan_addr_d  = '0;
          aged_count_d = '0;
        end
      end
      ST_RD: state_d = ST_EVAL;
      ST_EVAL: begin
        if (collide) begin
          state_d = ST_RD;
        end else if (stale) begin
          state_d = ST_WR;
        end else if (last_addr) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_RD;
          scan_addr_d = scan_addr_q + 1'b1;
        end
      end
      ST_WR: begin
        // a fresh add-port write wins; reread so the new entry is judged on its own timestamp
        if (collide) begin
          state_d = ST_RD;
        end else begin
          if (aged_count_q != (AW+1)'(DD)) aged_count_d = aged_count_q + 1'b1;
          if (last_addr) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_RD;
            scan_addr_d = scan_addr_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d     = ST_IDLE;
        scan_addr_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr_age       = (state_q == ST_RD || state_q == ST_WR) ? scan_addr_q : addr_hold_q;
  assign mem_write_age      = (state_q == ST_WR) && !collide && !p_reset;
  assign mem_write_data_age = '0;
  assign age_busy           = (state_q == ST_RD) || (state_q == ST_EVAL) || (state_q == ST_WR);
  assign age_done           = (state_q == ST_DONE);
  assign aged_count         = aged_count_q;
  assign age_state_dbg      = state_q;

endmodule
